// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, link rate constants and the
// default baud divisor. Used by uart_tx and the future uart_rx.
package uart_pkg;

    localparam int unsigned CLK_HZ               = 50_000_000;
    localparam int unsigned BAUD                 = 115_200;
    localparam int unsigned DEFAULT_CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int unsigned BYTE_W               = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_tx_if.sv
// Byte-in / serial-out handshake between the frame builder and uart_tx.
//   TX_DV     : byte-valid strobe (builder -> tx)
//   TX_BYTE   : byte to send      (builder -> tx)
//   TX_READY  : holding register empty (tx -> builder)
//   TX_SERIAL : serial line, idle high (tx -> pin)
//   TX_ACTIVE : frame on the line      (tx -> builder)
//   TX_DONE   : one-cycle end-of-frame pulse (tx -> builder)
interface uart_tx_if;
    import uart_pkg::*;

    logic              TX_DV;
    logic [BYTE_W-1:0] TX_BYTE;
    logic              TX_READY;
    logic              TX_SERIAL;
    logic              TX_ACTIVE;
    logic              TX_DONE;

    modport master (
        output TX_DV,
        output TX_BYTE,
        input  TX_READY,
        input  TX_SERIAL,
        input  TX_ACTIVE,
        input  TX_DONE
    );

    modport slave (
        input  TX_DV,
        input  TX_BYTE,
        output TX_READY,
        output TX_SERIAL,
        output TX_ACTIVE,
        output TX_DONE
    );

endinterface

// File: rtl/uart_bit_timer.sv
// Baud counter. Counts 0..CLKS_PER_BIT-1 and flags the last cycle of each
// bit period with a registered one-cycle bit_end tick.
//   CLK     : system clock
//   RST     : synchronous active-high reset
//   restart : hold the counter at 0 (next bit period starts on release)
//   bit_end : high during the final cycle of a bit period
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic CLK,
    input  logic RST,
    input  logic restart,
    output logic bit_end
);

    localparam int unsigned            CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]       CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] clk_cnt;

    // bit_end is registered one cycle early so it lines up with clk_cnt == last
    always_ff @(posedge CLK) begin
        if (RST || restart) begin
            clk_cnt <= '0;
            bit_end <= 1'b0;
        end else if (clk_cnt == CNT_LAST) begin
            clk_cnt <= '0;
            bit_end <= 1'b0;
        end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
            bit_end <= (clk_cnt == CNT_PRE);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 / 8N2 serial transmitter with a one-byte holding register so a queued
// byte follows the current frame without an idle gap.
//   CLK, RST : clock and synchronous active-high reset
//   tx       : slave side of uart_tx_if (TX_DV/TX_BYTE in; TX_READY,
//              TX_SERIAL, TX_ACTIVE, TX_DONE out, all registered)
// Outputs are registered from the current FSM state, so the line trails the
// state register by one cycle; TX_DONE and TX_ACTIVE share that alignment.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic     CLK,
    input  logic     RST,
    uart_tx_if.slave tx
);

    localparam logic [2:0] LAST_BIT  = 3'(BYTE_W - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

    uart_state_e       state_q, state_d;
    logic [BYTE_W-1:0] hold_byte_q, hold_byte_d;
    logic [BYTE_W-1:0] shift_byte_q, shift_byte_d;
    logic              hold_full_q, hold_full_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic              stop_idx_q, stop_idx_d;
    logic              serial_q, serial_d;
    logic              active_q, active_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;
    logic              accept;
    logic              bit_end;
    logic              timer_restart;

    assign accept       = tx.TX_DV && ready_q;
    assign tx.TX_READY  = ready_q;
    assign tx.TX_SERIAL = serial_q;
    assign tx.TX_ACTIVE = active_q;
    assign tx.TX_DONE   = done_q;

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .CLK     (CLK),
        .RST     (RST),
        .restart (timer_restart),
        .bit_end (bit_end)
    );

    // Next-state, datapath and output decode
    always_comb begin
        state_d       = state_q;
        hold_byte_d   = hold_byte_q;
        hold_full_d   = hold_full_q;
        shift_byte_d  = shift_byte_q;
        bit_idx_d     = bit_idx_q;
        stop_idx_d    = stop_idx_q;
        serial_d      = 1'b1;
        active_d      = 1'b1;
        done_d        = 1'b0;
        timer_restart = 1'b0;

        // ready_q low implies hold_full_q high, so this never collides with a transfer
        if (accept) begin
            hold_full_d = 1'b1;
            hold_byte_d = tx.TX_BYTE;
        end

        case (state_q)
            IDLE: begin
                active_d      = 1'b0;
                timer_restart = 1'b1;
                if (hold_full_q) begin
                    shift_byte_d = hold_byte_q;
                    hold_full_d  = 1'b0;
                    state_d      = START;
                end
            end
            START: begin
                serial_d = 1'b0;
                if (bit_end) begin
                    bit_idx_d = 3'd0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                serial_d = shift_byte_q[bit_idx_q];
                if (bit_end) begin
                    if (bit_idx_q == LAST_BIT) begin
                        stop_idx_d = 1'b0;
                        state_d    = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (stop_idx_q == LAST_STOP) begin
                        done_d = 1'b1;
                        // chain straight into the next frame when one is queued
                        if (hold_full_q) begin
                            shift_byte_d = hold_byte_q;
                            hold_full_d  = 1'b0;
                            state_d      = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = !hold_full_d;
    end

    // State, datapath and output registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            hold_byte_q  <= '0;
            hold_full_q  <= 1'b0;
            shift_byte_q <= '0;
            bit_idx_q    <= 3'd0;
            stop_idx_q   <= 1'b0;
            serial_q     <= 1'b1;
            active_q     <= 1'b0;
            done_q       <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            hold_byte_q  <= hold_byte_d;
            hold_full_q  <= hold_full_d;
            shift_byte_q <= shift_byte_d;
            bit_idx_q    <= bit_idx_d;
            stop_idx_q   <= stop_idx_d;
            serial_q     <= serial_d;
            active_q     <= active_d;
            done_q       <= done_d;
            ready_q      <= ready_d;
        end
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter for the motion-capture telemetry link: accepts bytes from the frame builder, which emits the "ST", point X/Y, "END" byte sequence, and shifts each byte out as 8N1 (or 8N2) asynchronous serial on the FPGA UART pin. It provides a one-byte holding register so back-to-back frames leave no idle gap on the line. It also generates the TX_DONE pulse that advances the frame builder's byte counter.

## Interface

**Parameters**
- `CLKS_PER_BIT`, default 434: clock cycles per serial bit (50 MHz / 115200 baud); legal range 4..65535.
- `STOP_BITS`, default 1: number of stop bits; legal values 1 or 2.

**Ports**
- `CLK`  in  1: system clock. One clock only; all logic is on the rising edge.
- `RST`  in  1: reset, synchronous and active-high.
- `TX_DV`  in  1: byte-valid strobe. A byte is accepted on a rising `CLK` edge where `TX_DV && TX_READY`.
- `TX_BYTE`  in  8: byte to send, sampled on acceptance.
- `TX_READY`  out  1: holding register empty; registered.
- `TX_SERIAL`  out  1: serial line, idle high; registered.
- `TX_ACTIVE`  out  1: high while a frame (start, data, stop) is on the line.
- `TX_DONE`  out  1: one-cycle pulse on the last cycle of the final stop bit; registered and glitch-free, so it is safe to use as an edge source downstream.

## Operation

- **Datapath**
  - Holding register `hold_byte` with flag `hold_full`; `TX_READY = !hold_full`, registered.
  - Shift register `shift_byte`, bit counter `bit_idx` (0..7), baud counter `clk_cnt` (0..CLKS_PER_BIT-1).
- **FSM states:** IDLE, START, DATA, STOP.
  - **IDLE:** `TX_SERIAL=1`. If `hold_full`, move `hold_byte` into `shift_byte`, clear `hold_full`, go to START.
  - **START:** `TX_SERIAL=0` for CLKS_PER_BIT cycles, then go to DATA with `bit_idx=0`.
  - **DATA:** `TX_SERIAL=shift_byte[bit_idx]`, LSB first, each bit held CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - **STOP:** `TX_SERIAL=1` for STOP_BITS*CLKS_PER_BIT cycles. On the final cycle, pulse `TX_DONE`. Then:
    - if `hold_full`, load the shifter, clear `hold_full` and go directly to START (no idle cycle);
    - otherwise go to IDLE.
- **Acceptance:** a byte is accepted in any state while `TX_READY`=1, including IDLE and mid-frame. `TX_DV` while `TX_READY`=0 is ignored; the byte is dropped and no error is flagged.
- **Simultaneous events:** hold-to-shifter transfer and a new `TX_DV` on the same edge. `TX_READY` is still 0 (registered), so the `TX_DV` is ignored. `TX_READY` rises the following cycle.
- **Counter wrap:** `clk_cnt` resets to 0 at every bit boundary. `bit_idx` never exceeds 7.
- **Reset mid-frame:** the frame is aborted and `hold_full` is cleared. The line returns high on the next cycle and no `TX_DONE` is emitted.

## Timing

- **Reset values:** `TX_SERIAL`=1, `TX_ACTIVE`=0, `TX_DONE`=0, `TX_READY`=1; FSM in IDLE, counters 0.
- **Latency from idle:** byte accepted at edge k → hold register loaded at edge k → FSM enters START at edge k+1 → `TX_SERIAL` low from edge k+2.
- **Frame length:** (1 + 8 + STOP_BITS) × CLKS_PER_BIT cycles of line time. Default is 4340 cycles.
- **`TX_DONE`:** high for exactly 1 cycle, coincident with the last stop-bit cycle.
- **Back-to-back frames:** with `hold_full`=1 at `TX_DONE`, the next start bit begins on the following cycle.
- **`TX_ACTIVE`:** rises with entry to START and falls on entry to IDLE. It stays high across back-to-back frames.
- **`TX_READY`:** falls the cycle after acceptance and rises the cycle after hold-to-shifter transfer.

## Structure

- **Shared package `uart_pkg`:**
  - state enum {IDLE, START, DATA, STOP};
  - constants `CLK_HZ`=50_000_000, `BAUD`=115200, default `CLKS_PER_BIT`.
  - The package is shared with the future `uart_rx`.
- **Sub-module `uart_bit_timer`:** baud counter emitting a one-cycle `bit_end` tick.
  - Inputs: `CLK`, `RST`, `restart`.
  - Parameter: `CLKS_PER_BIT`.
  - It is reused by `uart_rx` with a half-bit offset.
- The FSM, shifter and holding register stay in `uart_tx`.

## Test plan

- **Reset values:** assert `RST` for 3 cycles mid-idle → `TX_SERIAL`=1, `TX_READY`=1, `TX_ACTIVE`=0, `TX_DONE`=0.
- **Single byte:** `CLKS_PER_BIT`=8; send 0x53 from idle → line shows 0, then 1,1,0,0,1,0,1,0, then 1, each 8 cycles. `TX_DONE` pulses once, 80 cycles after the start bit begins.
- **Back-to-back:** send 0x45 then, while `TX_READY`=1, 0x4E → two contiguous frames with no idle cycle. `TX_ACTIVE` stays high throughout and there are two `TX_DONE` pulses 80 cycles apart.
- **Overrun:** with the hold register full, pulse `TX_DV` with 0xFF → byte dropped. Only the two queued bytes appear on the line.
- **Reset mid-frame:** assert `RST` during DATA bit 3 → line high on the next cycle. No `TX_DONE`, `TX_READY`=1, and the queued byte is discarded.
- **Stop-bit timing:** `STOP_BITS`=2, send 0x00 → stop interval is 16 cycles. `TX_DONE` is on the last stop cycle and the frame totals 88 cycles.
